// File: rtl/scan_io_harness.sv
// Serial scan harness: shifts a parallel DUT input bus in on di, captures the DUT output bus and shifts it out on sdo.
// The serial output port is sdo because "do" is a SystemVerilog keyword.
module scan_io_harness #(
  parameter int unsigned DIN_N         = 8,
  parameter int unsigned DOUT_N        = 8,
  parameter int unsigned CAPTURE_DELAY = 0,
  parameter int unsigned AUTO_STB      = 0,
  parameter int unsigned FCNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              di,
  input  logic              shift_en,
  input  logic              stb,
  output logic              sdo,
  output logic [DIN_N-1:0]  dut_din,
  input  logic [DOUT_N-1:0] dut_dout,
  output logic              busy,
  output logic              overrun,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int unsigned BCNT_W = (DIN_N > 1) ? $clog2(DIN_N) : 1;
  localparam int unsigned DCNT_W = 4;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DIN_N - 1);
  localparam logic [DCNT_W-1:0] DCNT_LOAD = DCNT_W'(CAPTURE_DELAY);
  localparam bit DELAYED = (CAPTURE_DELAY != 0);
  localparam bit AUTO    = (AUTO_STB != 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             state;
  logic [DIN_N-1:0]   din_shr;
  logic [DOUT_N-1:0]  dout_shr;
  logic [BCNT_W-1:0]  bcnt;
  logic [DCNT_W-1:0]  dcnt;
  logic               stb_auto;

  logic upd_c;
  logic cap_c;
  logic bcnt_wrap_c;

  // Strobe source, counter wrap and capture decision for this cycle
  assign upd_c       = AUTO ? stb_auto : stb;
  assign bcnt_wrap_c = shift_en && (bcnt == BCNT_LAST);
  assign cap_c       = (state == S_IDLE) ? (upd_c && !DELAYED)
                                         : (dcnt == DCNT_W'(1));

  assign sdo = dout_shr[DOUT_N-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      din_shr   <= '0;
      dout_shr  <= '0;
      dut_din   <= '0;
      bcnt      <= '0;
      dcnt      <= '0;
      stb_auto  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (shift_en) begin
        din_shr <= DIN_N'({din_shr, di});
        bcnt    <= bcnt_wrap_c ? '0 : bcnt + BCNT_W'(1);
      end

      // Single-cycle pulse; with DIN_N=1 the gap keeps it to every other cycle
      stb_auto <= bcnt_wrap_c && !stb_auto;

      if (upd_c) begin
        dut_din <= din_shr;
      end

      if (cap_c) begin
        dout_shr  <= dut_dout;
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end else if (shift_en) begin
        dout_shr <= dout_shr << 1;
      end

      case (state)
        S_IDLE: begin
          if (upd_c && DELAYED) begin
            state <= S_WAIT;
            dcnt  <= DCNT_LOAD;
            busy  <= 1'b1;
          end
        end
        S_WAIT: begin
          dcnt <= dcnt - DCNT_W'(1);
          if (upd_c) begin
            overrun <= 1'b1;
          end
          if (dcnt == DCNT_W'(1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_io_harness.sv
// Directed bench for scan_io_harness: default, delayed-capture and auto-strobe instances share one stimulus.
module tb_scan_io_harness;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       di;
  logic       shift_en;
  logic       stb;
  logic [7:0] dut_dout;

  logic       sdo_def, busy_def, ovr_def;
  logic [7:0] din_def, fc_def;
  logic       sdo_d2, busy_d2, ovr_d2;
  logic [7:0] din_d2, fc_d2;
  logic       sdo_au, busy_au, ovr_au;
  logic [7:0] din_au, fc_au;
  logic       sdo_d3, busy_d3, ovr_d3;
  logic [7:0] din_d3, fc_d3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scan_io_harness u_def (
    .clk(clk), .rst_n(rst_n), .di(di), .shift_en(shift_en), .stb(stb),
    .sdo(sdo_def), .dut_din(din_def), .dut_dout(dut_dout),
    .busy(busy_def), .overrun(ovr_def), .frame_cnt(fc_def));

  scan_io_harness #(.CAPTURE_DELAY(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .di(di), .shift_en(shift_en), .stb(stb),
    .sdo(sdo_d2), .dut_din(din_d2), .dut_dout(dut_dout),
    .busy(busy_d2), .overrun(ovr_d2), .frame_cnt(fc_d2));

  scan_io_harness #(.AUTO_STB(1)) u_auto (
    .clk(clk), .rst_n(rst_n), .di(di), .shift_en(shift_en), .stb(stb),
    .sdo(sdo_au), .dut_din(din_au), .dut_dout(dut_dout),
    .busy(busy_au), .overrun(ovr_au), .frame_cnt(fc_au));

  scan_io_harness #(.CAPTURE_DELAY(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .di(di), .shift_en(shift_en), .stb(stb),
    .sdo(sdo_d3), .dut_din(din_d3), .dut_dout(dut_dout),
    .busy(busy_d3), .overrun(ovr_d3), .frame_cnt(fc_d3));

  typedef struct {
    logic       di;
    logic       sh;
    logic       stb;
    logic [7:0] dd;
    logic [7:0] e_din;
    logic       e_sdo;
    logic [7:0] e_fc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic a_di, input logic a_sh, input logic a_stb, input logic [7:0] a_dd,
                     input logic [7:0] a_din, input logic a_sdo, input logic [7:0] a_fc);
    vec_t v;
    v.di = a_di; v.sh = a_sh; v.stb = a_stb; v.dd = a_dd;
    v.e_din = a_din; v.e_sdo = a_sdo; v.e_fc = a_fc;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; di = 1'b0; shift_en = 1'b0; stb = 1'b0; dut_dout = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i < last; i++) begin
      di = tbl[i].di; shift_en = tbl[i].sh; stb = tbl[i].stb; dut_dout = tbl[i].dd;
      tick();
      chk($sformatf("row%0d_din", i), 32'(din_def), 32'(tbl[i].e_din));
      chk($sformatf("row%0d_sdo", i), 32'(sdo_def), 32'(tbl[i].e_sdo));
      chk($sformatf("row%0d_fc", i), 32'(fc_def), 32'(tbl[i].e_fc));
      chk($sformatf("row%0d_busy", i), 32'(busy_def), 32'(0));
      chk($sformatf("row%0d_ovr", i), 32'(ovr_def), 32'(0));
    end
  endtask

  initial begin
    logic [7:0]  acc;
    logic [15:0] stream;
    logic [7:0]  val;
    int          t4_start;

    // Legacy shift of 0xA5, strobe, capture 0x3C, serialise
    add(1, 1, 0, 8'h3C, 8'h00, 0, 8'd0);
    add(0, 1, 0, 8'h3C, 8'h00, 0, 8'd0);
    add(1, 1, 0, 8'h3C, 8'h00, 0, 8'd0);
    add(0, 1, 0, 8'h3C, 8'h00, 0, 8'd0);
    add(0, 1, 0, 8'h3C, 8'h00, 0, 8'd0);
    add(1, 1, 0, 8'h3C, 8'h00, 0, 8'd0);
    add(0, 1, 0, 8'h3C, 8'h00, 0, 8'd0);
    add(1, 1, 0, 8'h3C, 8'h00, 0, 8'd0);
    add(0, 1, 1, 8'h3C, 8'hA5, 0, 8'd1);
    add(0, 1, 0, 8'h00, 8'hA5, 0, 8'd1);
    add(0, 1, 0, 8'h00, 8'hA5, 1, 8'd1);
    add(0, 1, 0, 8'h00, 8'hA5, 1, 8'd1);
    add(0, 1, 0, 8'h00, 8'hA5, 1, 8'd1);
    add(0, 1, 0, 8'h00, 8'hA5, 1, 8'd1);
    add(0, 1, 0, 8'h00, 8'hA5, 0, 8'd1);
    add(0, 1, 0, 8'h00, 8'hA5, 0, 8'd1);
    t4_start = tbl.size();
    // Gapped shift of 0x81 with junk di on disabled cycles; sdo walks 0xC3
    add(0, 0, 1, 8'hC3, 8'h00, 1, 8'd1);
    add(1, 1, 0, 8'hC3, 8'h00, 1, 8'd1);
    add(0, 0, 0, 8'hC3, 8'h00, 1, 8'd1);
    add(0, 1, 0, 8'hC3, 8'h00, 0, 8'd1);
    add(1, 0, 0, 8'hC3, 8'h00, 0, 8'd1);
    add(0, 1, 0, 8'hC3, 8'h00, 0, 8'd1);
    add(1, 0, 0, 8'hC3, 8'h00, 0, 8'd1);
    add(0, 1, 0, 8'hC3, 8'h00, 0, 8'd1);
    add(1, 0, 0, 8'hC3, 8'h00, 0, 8'd1);
    add(0, 1, 0, 8'hC3, 8'h00, 0, 8'd1);
    add(1, 0, 0, 8'hC3, 8'h00, 0, 8'd1);
    add(0, 1, 0, 8'hC3, 8'h00, 1, 8'd1);
    add(1, 0, 0, 8'hC3, 8'h00, 1, 8'd1);
    add(0, 1, 0, 8'hC3, 8'h00, 1, 8'd1);
    add(1, 0, 0, 8'hC3, 8'h00, 1, 8'd1);
    add(1, 1, 0, 8'hC3, 8'h00, 0, 8'd1);
    add(0, 0, 0, 8'hC3, 8'h00, 0, 8'd1);
    add(0, 0, 1, 8'h5A, 8'h81, 0, 8'd2);

    // Reset state of every instance
    do_reset();
    chk("rst_def", {22'd0, sdo_def, busy_def, ovr_def, din_def, fc_def}, 32'd0);
    chk("rst_d2",  {22'd0, sdo_d2,  busy_d2,  ovr_d2,  din_d2,  fc_d2},  32'd0);
    chk("rst_au",  {22'd0, sdo_au,  busy_au,  ovr_au,  din_au,  fc_au},  32'd0);
    chk("rst_d3",  {22'd0, sdo_d3,  busy_d3,  ovr_d3,  din_d3,  fc_d3},  32'd0);

    run_rows(0, t4_start);
    do_reset();
    run_rows(t4_start, tbl.size());

    // Capture delay 2, dut_dout moves one cycle after the strobe
    do_reset();
    dut_dout = 8'h11; stb = 1'b1;
    tick();
    chk("d2_busy0", 32'(busy_d2), 32'(1));
    chk("d2_fc0", 32'(fc_d2), 32'(0));
    stb = 1'b0; dut_dout = 8'h22;
    tick();
    chk("d2_busy1", 32'(busy_d2), 32'(1));
    chk("d2_fc1", 32'(fc_d2), 32'(0));
    tick();
    chk("d2_busy2", 32'(busy_d2), 32'(0));
    chk("d2_fc2", 32'(fc_d2), 32'(1));
    acc = {7'd0, sdo_d2};
    shift_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      acc = {acc[6:0], sdo_d2};
    end
    chk("d2_serial", 32'(acc), 32'h22);
    chk("d2_ovr", 32'(ovr_d2), 32'(0));

    // Auto strobe over a 16-bit stream with a toggling stb pin
    do_reset();
    stream = 16'hF00F;
    for (int e = 1; e <= 17; e++) begin
      shift_en = (e <= 16);
      di = (e <= 16) ? stream[16-e] : 1'b0;
      stb = 1'($urandom_range(0, 1));
      tick();
      if (e == 8 || e == 9 || e == 16 || e == 17) begin
        val = (e == 8) ? 8'h00 : (e == 17) ? 8'h0F : 8'hF0;
        chk($sformatf("au_din_e%0d", e), 32'(din_au), 32'(val));
        val = (e == 8) ? 8'd0 : (e == 17) ? 8'd2 : 8'd1;
        chk($sformatf("au_fc_e%0d", e), 32'(fc_au), 32'(val));
      end
    end
    chk("au_ovr", 32'(ovr_au), 32'(0));

    // Capture delay 3 with a second strobe while waiting
    do_reset();
    dut_dout = 8'h99; shift_en = 1'b1;
    val = 8'hB4;
    for (int i = 7; i >= 0; i--) begin
      di = val[i];
      tick();
    end
    di = 1'b1; stb = 1'b1;
    tick();
    chk("d3_din1", 32'(din_d3), 32'hB4);
    chk("d3_busy1", 32'(busy_d3), 32'(1));
    chk("d3_ovr1", 32'(ovr_d3), 32'(0));
    shift_en = 1'b0;
    tick();
    chk("d3_din2", 32'(din_d3), 32'h69);
    chk("d3_ovr2", 32'(ovr_d3), 32'(1));
    stb = 1'b0;
    tick();
    chk("d3_busy3", 32'(busy_d3), 32'(1));
    chk("d3_fc3", 32'(fc_d3), 32'(0));
    tick();
    chk("d3_busy4", 32'(busy_d3), 32'(0));
    chk("d3_fc4", 32'(fc_d3), 32'(1));
    chk("d3_sdo4", 32'(sdo_d3), 32'(1));
    for (int i = 0; i < 6; i++) tick();
    chk("d3_fc_end", 32'(fc_d3), 32'(1));
    chk("d3_ovr_end", 32'(ovr_d3), 32'(1));

    // Asynchronous reset while a capture is pending
    do_reset();
    dut_dout = 8'hFF; shift_en = 1'b1; di = 1'b1;
    tick();
    shift_en = 1'b0; stb = 1'b1;
    tick();
    chk("r6_busy", 32'(busy_d3), 32'(1));
    chk("r6_din", 32'(din_d3), 32'h01);
    stb = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("r6_async", {22'd0, sdo_d3, busy_d3, ovr_d3, din_d3, fc_d3}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("r6_nocap_fc", 32'(fc_d3), 32'(0));
    chk("r6_nocap_sdo", 32'(sdo_d3), 32'(0));
    chk("r6_nocap_busy", 32'(busy_d3), 32'(0));
    stb = 1'b1;
    tick();
    stb = 1'b0;
    chk("r6_busy2", 32'(busy_d3), 32'(1));
    tick();
    tick();
    tick();
    chk("r6_fc", 32'(fc_d3), 32'(1));
    chk("r6_sdo", 32'(sdo_d3), 32'(1));
    chk("r6_busy3", 32'(busy_d3), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
